// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } chan_state_t;

    localparam int unsigned MIN_RATIO = 2;

    // High-phase length of one period: ceil(a/2), so odd ratios run high one cycle longer.
    function automatic int unsigned half_hi(input int unsigned a);
        return (a + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active ratio, registered clk_out/cfg_err.
// Optional tick output is built only when CLK_DIV_TICK_EN is defined.
//
// state | meaning
// IDLE  | stopped, clk_out low, tracking div_ratio every cycle
// RUN   | producing periods, ratio resampled at each wrap
// DRAIN | enable dropped, finishing the current period before stopping
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic [WIDTH-1:0] ratio,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_err
);

    chan_state_t      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic             clk_q, clk_d;
    logic             err_q, err_d;
    logic             start;

    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] last;
    logic             ratio_ok;
    logic             wrap;

    assign ratio_ok = 32'(ratio) >= MIN_RATIO;
    assign half     = WIDTH'(half_hi(32'(act_q)));
    assign last     = act_q - WIDTH'(1);
    assign wrap     = (cnt_q == last);
    assign cnt_inc  = cnt_q + WIDTH'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        clk_d   = 1'b0;
        err_d   = 1'b0;
        start   = 1'b0;

        // A sync strobe restarts an enabled, validly configured channel from any state.
        if (sync && enable && ratio_ok) begin
            start   = 1'b1;
            act_d   = ratio;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    act_d = ratio;
                    cnt_d = '0;
                    err_d = enable && !ratio_ok;
                    if (enable && ratio_ok) begin
                        start   = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (wrap) begin
                        act_d = ratio;
                        cnt_d = '0;
                        if (enable && ratio_ok) begin
                            start   = 1'b1;
                            state_d = RUN;
                        end else begin
                            state_d = IDLE;
                            err_d   = enable;
                        end
                    end else begin
                        // Mid-period: ratio is ignored so the period is never cut or stretched.
                        cnt_d   = cnt_inc;
                        clk_d   = cnt_inc < half;
                        state_d = enable ? RUN : DRAIN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (start) begin
            clk_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= '0;
            clk_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            clk_q   <= clk_d;
            err_q   <= err_d;
        end
    end

    assign clk_out = clk_q;
    assign cfg_err = err_q;

`ifdef CLK_DIV_TICK_EN
    logic tick_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= start;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: CHANNELS independent clk_div_chan instances.
// Define CLK_DIV_TICK_EN to build the per-channel tick pulse; otherwise tick reads 0.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      sync,
    input  logic [CHANNELS*WIDTH-1:0] div_ratio,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       cfg_err
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_div_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable[i]),
            .sync    (sync),
            .ratio   (div_ratio[i*WIDTH +: WIDTH]),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .cfg_err (cfg_err[i])
        );
    end

endmodule
